// File: rtl/ts_addr_bus_ctrl.sv
// Single-master address decoder that replaces a shared tri-state data line with an explicit mux.
// Two register stages: address/valid capture, then resolved data, data-valid and sticky collision flag.
module ts_addr_bus_ctrl #(
    parameter int unsigned                    ADDR_W     = 8,
    parameter int unsigned                    NUM_SLAVES = 2,
    parameter logic [NUM_SLAVES*ADDR_W-1:0]   SLAVE_ADDR = {8'd42, 8'd50}
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_W-1:0]      mst_adrs,
    input  logic                   mst_adrs_vld,
    input  logic [NUM_SLAVES-1:0]  slv_data,
    output logic [NUM_SLAVES-1:0]  slv_sel,
    output logic                   mst_data,
    output logic                   mst_data_vld,
    output logic                   addr_collide
);

    localparam logic [NUM_SLAVES-1:0] SEL_ZERO = {NUM_SLAVES{1'b0}};
    localparam logic [NUM_SLAVES-1:0] SEL_ONE  = NUM_SLAVES'(1);

    // Isolate the lowest set bit so the lowest-index slave always wins the grant.
    function automatic logic [NUM_SLAVES-1:0] lowest_set(input logic [NUM_SLAVES-1:0] vec);
        return vec & (~vec + SEL_ONE);
    endfunction

    // True when two or more bits of the vector are set.
    function automatic logic multi_set(input logic [NUM_SLAVES-1:0] vec);
        return (vec & (vec - SEL_ONE)) != SEL_ZERO;
    endfunction

    logic [ADDR_W-1:0]     adrs_r;
    logic                  vld_r;
    logic [NUM_SLAVES-1:0] match_s;
    logic [NUM_SLAVES-1:0] sel_s;
    logic                  hit_s;
    logic                  data_s;
    logic                  collide_s;
    logic                  mst_data_r;
    logic                  mst_data_vld_r;
    logic                  addr_collide_r;

    // Stage 1: capture the master address and its qualifier every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            adrs_r <= {ADDR_W{1'b0}};
            vld_r  <= 1'b0;
        end else begin
            adrs_r <= mst_adrs;
            vld_r  <= mst_adrs_vld;
        end
    end

    // Exact full-width compare of the captured address against every slave address.
    always_comb begin
        match_s = SEL_ZERO;
        for (int i = 0; i < int'(NUM_SLAVES); i++) begin
            if (vld_r && (adrs_r == SLAVE_ADDR[i*ADDR_W +: ADDR_W])) begin
                match_s[i] = 1'b1;
            end else begin
                match_s[i] = 1'b0;
            end
        end
    end

    // Grant and resolved data; AND-masking keeps ungranted slave lines out of the result.
    always_comb begin
        sel_s     = lowest_set(match_s);
        hit_s     = |match_s;
        collide_s = multi_set(match_s);
        if (hit_s) begin
            data_s = |(sel_s & slv_data);
        end else begin
            data_s = 1'b0;
        end
    end

    // Stage 2: register data, data-valid and the sticky collision flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mst_data_r     <= 1'b0;
            mst_data_vld_r <= 1'b0;
            addr_collide_r <= 1'b0;
        end else begin
            mst_data_r     <= data_s;
            mst_data_vld_r <= hit_s;
            addr_collide_r <= addr_collide_r | collide_s;
        end
    end

    assign slv_sel      = sel_s;
    assign mst_data     = mst_data_r;
    assign mst_data_vld = mst_data_vld_r;
    assign addr_collide = addr_collide_r;

endmodule

// File: tb/tb_ts_addr_bus_ctrl.sv
// Directed bench: table of single-address transactions plus hand-written pipeline, reset and collision sequences.
module tb_ts_addr_bus_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] mst_adrs;
    logic       mst_adrs_vld;
    logic [1:0] slv_data;
    logic [1:0] slv_sel;
    logic       mst_data;
    logic       mst_data_vld;
    logic       addr_collide;
    logic [1:0] c_sel;
    logic       c_data;
    logic       c_vld;
    logic       c_collide;

    int total;
    int passed;

    ts_addr_bus_ctrl #(.ADDR_W(8), .NUM_SLAVES(2), .SLAVE_ADDR({8'd42, 8'd50})) dut (
        .clk(clk), .rst_n(rst_n), .mst_adrs(mst_adrs), .mst_adrs_vld(mst_adrs_vld),
        .slv_data(slv_data), .slv_sel(slv_sel), .mst_data(mst_data),
        .mst_data_vld(mst_data_vld), .addr_collide(addr_collide)
    );

    ts_addr_bus_ctrl #(.ADDR_W(8), .NUM_SLAVES(2), .SLAVE_ADDR({8'd42, 8'd42})) dut_dup (
        .clk(clk), .rst_n(rst_n), .mst_adrs(mst_adrs), .mst_adrs_vld(mst_adrs_vld),
        .slv_data(slv_data), .slv_sel(c_sel), .mst_data(c_data),
        .mst_data_vld(c_vld), .addr_collide(c_collide)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] adrs;
        logic       vld;
        logic [1:0] sd;
        logic [1:0] exp_sel;
        logic       exp_data;
        logic       exp_vld;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] a, input logic v, input logic [1:0] sd);
        mst_adrs     = a;
        mst_adrs_vld = v;
        slv_data     = sd;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        vecs[0] = '{8'd50,  1'b1, 2'b01, 2'b01, 1'b1, 1'b1};
        vecs[1] = '{8'd50,  1'b1, 2'b10, 2'b01, 1'b0, 1'b1};
        vecs[2] = '{8'd42,  1'b1, 2'b10, 2'b10, 1'b1, 1'b1};
        vecs[3] = '{8'd42,  1'b1, 2'b01, 2'b10, 1'b0, 1'b1};
        vecs[4] = '{8'd7,   1'b1, 2'b11, 2'b00, 1'b0, 1'b0};
        vecs[5] = '{8'd42,  1'b0, 2'b11, 2'b00, 1'b0, 1'b0};
        vecs[6] = '{8'd51,  1'b1, 2'b11, 2'b00, 1'b0, 1'b0};
        vecs[7] = '{8'hAA,  1'b1, 2'b11, 2'b00, 1'b0, 1'b0};
        vecs[8] = '{8'd50,  1'b1, 2'b11, 2'b01, 1'b1, 1'b1};

        // Reset held with clock and slave data toggling.
        rst_n = 1'b0;
        drive(8'd50, 1'b1, 2'b01);
        tick();
        drive(8'd42, 1'b1, 2'b10);
        tick();
        drive(8'd42, 1'b1, 2'b11);
        tick();
        check("rst_sel",      {6'd0, slv_sel},      8'd0);
        check("rst_data",     {7'd0, mst_data},     8'd0);
        check("rst_vld",      {7'd0, mst_data_vld}, 8'd0);
        check("rst_collide",  {7'd0, addr_collide}, 8'd0);
        check("rst_dup_coll", {7'd0, c_collide},    8'd0);
        check("rst_dup_sel",  {6'd0, c_sel},        8'd0);

        drive(8'd0, 1'b0, 2'b00);
        #2 rst_n = 1'b1;
        tick();

        // Table of isolated transactions: select one edge later, data two edges later.
        for (int k = 0; k < 9; k++) begin
            drive(vecs[k].adrs, vecs[k].vld, vecs[k].sd);
            tick();
            check($sformatf("vec%0d_sel", k), {6'd0, slv_sel}, {6'd0, vecs[k].exp_sel});
            tick();
            check($sformatf("vec%0d_data", k), {7'd0, mst_data}, {7'd0, vecs[k].exp_data});
            check($sformatf("vec%0d_vld", k), {7'd0, mst_data_vld}, {7'd0, vecs[k].exp_vld});
            check($sformatf("vec%0d_coll", k), {7'd0, addr_collide}, 8'd0);
        end

        // Back-to-back addresses 50 then 42 with slv_data=10.
        drive(8'd0, 1'b0, 2'b10);
        tick();
        tick();
        drive(8'd50, 1'b1, 2'b10);
        tick();
        check("b2b_sel0", {6'd0, slv_sel}, 8'd1);
        drive(8'd42, 1'b1, 2'b10);
        tick();
        check("b2b_data0", {7'd0, mst_data}, 8'd0);
        check("b2b_vld0",  {7'd0, mst_data_vld}, 8'd1);
        check("b2b_sel1",  {6'd0, slv_sel}, 8'd2);
        drive(8'd0, 1'b0, 2'b10);
        tick();
        check("b2b_data1", {7'd0, mst_data}, 8'd1);
        check("b2b_vld1",  {7'd0, mst_data_vld}, 8'd1);
        check("b2b_sel2",  {6'd0, slv_sel}, 8'd0);
        tick();
        check("b2b_vld2",  {7'd0, mst_data_vld}, 8'd0);

        // Async reset between the address and data edges, with earlier outputs still valid.
        drive(8'd50, 1'b1, 2'b01);
        tick();
        tick();
        check("ar_pre_vld", {7'd0, mst_data_vld}, 8'd1);
        check("ar_pre_sel", {6'd0, slv_sel}, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        check("ar_sel",  {6'd0, slv_sel},      8'd0);
        check("ar_data", {7'd0, mst_data},     8'd0);
        check("ar_vld",  {7'd0, mst_data_vld}, 8'd0);
        drive(8'd0, 1'b0, 2'b01);
        #2 rst_n = 1'b1;
        tick();
        check("ar_post_sel", {6'd0, slv_sel}, 8'd0);
        tick();
        check("ar_post_vld", {7'd0, mst_data_vld}, 8'd0);
        drive(8'd42, 1'b1, 2'b10);
        tick();
        tick();
        check("ar_new_vld",  {7'd0, mst_data_vld}, 8'd1);
        check("ar_new_data", {7'd0, mst_data}, 8'd1);

        // Duplicate-address instance: fresh reset, then address 42 on both slaves.
        rst_n = 1'b0;
        drive(8'd0, 1'b0, 2'b10);
        #3 rst_n = 1'b1;
        tick();
        check("dup_coll_init", {7'd0, c_collide}, 8'd0);
        drive(8'd42, 1'b1, 2'b10);
        tick();
        check("dup_sel", {6'd0, c_sel}, 8'd1);
        drive(8'd7, 1'b1, 2'b10);
        tick();
        check("dup_data", {7'd0, c_data},    8'd0);
        check("dup_vld",  {7'd0, c_vld},     8'd1);
        check("dup_coll", {7'd0, c_collide}, 8'd1);
        check("main_no_coll", {7'd0, addr_collide}, 8'd0);
        tick();
        tick();
        tick();
        check("dup_coll_hold", {7'd0, c_collide}, 8'd1);
        check("dup_vld_miss",  {7'd0, c_vld},     8'd0);
        #2 rst_n = 1'b0;
        #1;
        check("dup_coll_clr", {7'd0, c_collide}, 8'd0);
        #2 rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
